// File: rtl/nanomig_ram_pkg.sv
// Shared types and constants for the chip/kick RAM turbo arbiter.
//   state_t      - arbiter FSM states
//   KICK_PREFIX  - upper byte-address bits [23:19] of the kickstart image
//   SLOT_CYCLES  - clk_sys cycles per 7 MHz slot
//   is_kick()    - true when a word address [23:1] falls in 0xF80000-0xFFFFFF
package nanomig_ram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [4:0] KICK_PREFIX = 5'b11111;
   localparam int         SLOT_CYCLES = 4;

   // Word address vectors are [22:0] == byte address [23:1], so byte
   // address bits [23:19] live in [22:18].
   function automatic logic is_kick(input logic [22:0] word_addr);
      return word_addr[22:18] == KICK_PREFIX;
   endfunction

endpackage

// File: rtl/ram_port_mux.sv
// Combinational owner mux for the shared RAM port plus kickstart write
// protection.
//   cpu_owner=0 : every ram_* output follows the chipset strobes.
//   cpu_owner=1 : ram_* driven from the CPU request; writes into the
//                 kickstart image are masked when KICK_PROTECT is set.
// Ports: chip_* (chipset bus), cpu_* (CPU fast path), ram_* (RAM port).
module ram_port_mux
   import nanomig_ram_pkg::*;
#(
   parameter int KICK_PROTECT = 1
) (
   input  logic        cpu_owner,
   input  logic        chip_oe_n,
   input  logic        chip_we_n,
   input  logic        chip_bhe_n,
   input  logic        chip_ble_n,
   input  logic        chip_refresh,
   input  logic [22:0] chip_addr,
   input  logic [15:0] chip_wdata,
   input  logic        cpu_rnw,
   input  logic        cpu_uds,
   input  logic        cpu_lds,
   input  logic [22:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [22:0] ram_addr,
   output logic [15:0] ram_data,
   output logic        ram_oe_n,
   output logic        ram_we_n,
   output logic        ram_bhe_n,
   output logic        ram_ble_n,
   output logic        ram_refresh
);

   logic wp;

   assign wp = (KICK_PROTECT != 0) && is_kick(cpu_addr);

   always_comb begin
      ram_addr    = chip_addr;
      ram_data    = chip_wdata;
      ram_oe_n    = chip_oe_n;
      ram_we_n    = chip_we_n;
      ram_bhe_n   = chip_bhe_n;
      ram_ble_n   = chip_ble_n;
      ram_refresh = chip_refresh;
      if (cpu_owner) begin
         ram_addr    = cpu_addr;
         ram_data    = cpu_wdata;
         ram_oe_n    = !cpu_rnw;
         // Protected writes still run the full sequence, just without a strobe.
         ram_we_n    = cpu_rnw | wp;
         ram_bhe_n   = !cpu_uds;
         ram_ble_n   = !cpu_lds;
         ram_refresh = 1'b0;
      end
   end

endmodule

// File: rtl/ram_turbo_arbiter.sv
// Shares the chip/kick RAM port between the minimig chipset and the CPU
// fast path. Chipset cycles (including refresh) always win; the CPU only
// gets 7 MHz slots the chipset leaves idle.
// Ports: clk_sys/reset (sync, active-high), clk7_en slot strobe, chip_*
// chipset bus, cpu_* fast-path request/response, ramdata_in/ram_* RAM port,
// conflict (sticky pre-emption flag).
// Build option: TURBO_WRITE_EN - when defined CPU writes also use free
// slots; otherwise writes are answered with cpu_reject.
//
// state | meaning
// IDLE  | chipset owns RAM; grant decision at clk7_en
// ISSUE | CPU drives RAM for RAM_LAT cycles, read data captured on the last
// DONE  | cpu_ready pulse, back to IDLE
module ram_turbo_arbiter
   import nanomig_ram_pkg::*;
#(
   parameter int RAM_LAT      = 2,
   parameter int KICK_PROTECT = 1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        clk7_en,
   input  logic        chip_oe_n,
   input  logic        chip_we_n,
   input  logic        chip_bhe_n,
   input  logic        chip_ble_n,
   input  logic        chip_refresh,
   input  logic [22:0] chip_addr,
   input  logic [15:0] chip_wdata,
   input  logic        cpu_sel,
   input  logic        cpu_rnw,
   input  logic        cpu_uds,
   input  logic        cpu_lds,
   input  logic [22:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        cpu_reject,
   input  logic [15:0] ramdata_in,
   output logic [22:0] ram_addr,
   output logic [15:0] ram_data,
   output logic        ram_oe_n,
   output logic        ram_we_n,
   output logic        ram_bhe_n,
   output logic        ram_ble_n,
   output logic        ram_refresh,
   output logic        conflict
);

   localparam int              CW   = $clog2(SLOT_CYCLES);
   localparam logic [CW-1:0]   LAST = CW'(RAM_LAT - 1);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            chip_busy;
   logic            accept;
   logic            cpu_owner;
   logic            capture;
   logic            preempt;
   logic            reject_nxt;

   assign chip_busy = !chip_oe_n | !chip_we_n | chip_refresh;

`ifdef TURBO_WRITE_EN
   assign accept = 1'b1;
`else
   assign accept = cpu_rnw;
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         cpu_rdata  <= '0;
         cpu_reject <= 1'b0;
         conflict   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         cpu_reject <= reject_nxt;
         if (capture)
            cpu_rdata <= ramdata_in;
         if (preempt)
            conflict <= 1'b1;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      cpu_ready  = 1'b0;
      cpu_owner  = 1'b0;
      capture    = 1'b0;
      preempt    = 1'b0;
      reject_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (clk7_en && !chip_busy && cpu_sel) begin
               if (accept) begin
                  state_nxt = ISSUE;
                  cnt_nxt   = '0;
               end else begin
                  reject_nxt = 1'b1;
               end
            end
         end
         ISSUE: begin
            // The chipset takes the port back in the very cycle it asks for
            // it; cpu_sel stays up, so the access retries at a later slot.
            if (chip_busy) begin
               preempt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               cpu_owner = 1'b1;
               cnt_nxt   = cnt + 1'b1;
               if (cnt == LAST) begin
                  capture   = cpu_rnw;
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            cpu_ready = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   ram_port_mux #(
      .KICK_PROTECT (KICK_PROTECT)
   ) u_mux (
      .cpu_owner    (cpu_owner),
      .chip_oe_n    (chip_oe_n),
      .chip_we_n    (chip_we_n),
      .chip_bhe_n   (chip_bhe_n),
      .chip_ble_n   (chip_ble_n),
      .chip_refresh (chip_refresh),
      .chip_addr    (chip_addr),
      .chip_wdata   (chip_wdata),
      .cpu_rnw      (cpu_rnw),
      .cpu_uds      (cpu_uds),
      .cpu_lds      (cpu_lds),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .ram_addr     (ram_addr),
      .ram_data     (ram_data),
      .ram_oe_n     (ram_oe_n),
      .ram_we_n     (ram_we_n),
      .ram_bhe_n    (ram_bhe_n),
      .ram_ble_n    (ram_ble_n),
      .ram_refresh  (ram_refresh)
   );

endmodule

// File: tb/tb_ram_turbo_arbiter.sv
module tb_ram_turbo_arbiter;

   localparam int RAM_LAT = 2;

   logic        clk_sys, reset, clk7_en;
   logic        chip_oe_n, chip_we_n, chip_bhe_n, chip_ble_n, chip_refresh;
   logic [22:0] chip_addr;
   logic [15:0] chip_wdata;
   logic        cpu_sel, cpu_rnw, cpu_uds, cpu_lds;
   logic [22:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ready, cpu_reject;
   logic [15:0] ramdata_in;
   logic [22:0] ram_addr;
   logic [15:0] ram_data;
   logic        ram_oe_n, ram_we_n, ram_bhe_n, ram_ble_n, ram_refresh;
   logic        conflict;

   ram_turbo_arbiter #(.RAM_LAT(RAM_LAT), .KICK_PROTECT(1)) dut (
      .clk_sys(clk_sys), .reset(reset), .clk7_en(clk7_en),
      .chip_oe_n(chip_oe_n), .chip_we_n(chip_we_n), .chip_bhe_n(chip_bhe_n),
      .chip_ble_n(chip_ble_n), .chip_refresh(chip_refresh),
      .chip_addr(chip_addr), .chip_wdata(chip_wdata),
      .cpu_sel(cpu_sel), .cpu_rnw(cpu_rnw), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_reject(cpu_reject),
      .ramdata_in(ramdata_in), .ram_addr(ram_addr), .ram_data(ram_data),
      .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_bhe_n(ram_bhe_n),
      .ram_ble_n(ram_ble_n), .ram_refresh(ram_refresh), .conflict(conflict)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // RAM model: data valid only from the RAM_LAT-th cycle of a read.
   logic [15:0] mem [0:1023];
   int          oe_cnt;

   function automatic logic [9:0] midx(input logic [22:0] a);
      return {a[22:18], a[4:0]};
   endfunction

   always @(posedge clk_sys) begin
      oe_cnt = ram_oe_n ? 0 : oe_cnt + 1;
      if (!ram_we_n) begin
         if (!ram_bhe_n) mem[midx(ram_addr)][15:8] = ram_data[15:8];
         if (!ram_ble_n) mem[midx(ram_addr)][7:0]  = ram_data[7:0];
      end
   end

   always_comb begin
      ramdata_in = 16'hDEAD;
      if (!ram_oe_n && oe_cnt >= RAM_LAT - 1)
         ramdata_in = mem[midx(ram_addr)];
   end

   int          n_pass, n_total, phase;
   bit          slots_on;
   logic [15:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
      phase   = (phase + 1) % 4;
      clk7_en = slots_on && (phase == 0);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic wait_slot();
      for (int k = 0; k < 8 && !clk7_en; k++) tick();
      if (!clk7_en) chk("slot_timeout", 64'(clk7_en), 64'd1);
   endtask

   // Tick until cpu_ready; check latency in ticks and pop the scoreboard.
   task automatic wait_ready(input string name, input int exp_ticks);
      int c;
      c = 0;
      while (c < exp_ticks + 6) begin
         tick(); settle(); c++;
         if (cpu_ready) break;
      end
      chk({name, "_ready"}, 64'(cpu_ready), 64'd1);
      chk({name, "_lat"}, 64'(c), 64'(exp_ticks));
      if (cpu_ready && exp_q.size() > 0)
         chk({name, "_rdata"}, 64'(cpu_rdata), 64'(exp_q.pop_front()));
      cpu_sel = 1'b0;
   endtask

   typedef struct {
      logic        oe_n, we_n, bhe_n, ble_n, refresh;
      logic [22:0] addr;
      logic [15:0] wdata;
      logic [43:0] exp_ram;   // {refresh, bhe_n, ble_n, we_n, oe_n, addr, data}
   } vec_t;

   vec_t vecs [5];

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      n_pass = 0; n_total = 0; phase = 0; slots_on = 0; oe_cnt = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[midx(23'h0A0000)] = 16'hBEEF;
      mem[midx(23'h0A0002)] = 16'h0F0F;
      mem[midx(23'h0A0001)] = 16'h1357;
      mem[midx(23'h7C0002)] = 16'h5555;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h000100, 16'h0000,
                  {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 23'h000100, 16'h0000}};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 23'h012345, 16'h5A5A,
                  {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 23'h012345, 16'h5A5A}};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 23'h7FFFFF, 16'hFFFF,
                  {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 23'h7FFFFF, 16'hFFFF}};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 23'h000002, 16'h1111,
                  {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 23'h000002, 16'h1111}};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 23'h400000, 16'h8001,
                  {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h400000, 16'h8001}};

      clk7_en = 0; chip_oe_n = 1; chip_we_n = 1; chip_bhe_n = 1; chip_ble_n = 1;
      chip_refresh = 0; chip_addr = '0; chip_wdata = '0;
      cpu_sel = 0; cpu_rnw = 1; cpu_uds = 1; cpu_lds = 1;
      cpu_addr = '0; cpu_wdata = '0;
      reset = 1;
      repeat (3) tick();
      reset = 0;
      settle();
      chk("rst_ready",    64'(cpu_ready),  64'd0);
      chk("rst_reject",   64'(cpu_reject), 64'd0);
      chk("rst_rdata",    64'(cpu_rdata),  64'd0);
      chk("rst_conflict", 64'(conflict),   64'd0);
      chk("rst_oe_n",     64'(ram_oe_n),   64'd1);

      // Passthrough vectors: CPU requesting, but no slot strobe.
      cpu_sel = 1; cpu_rnw = 1; cpu_addr = 23'h0A0000; cpu_wdata = 16'hAAAA;
      for (int i = 0; i < 5; i++) begin
         chip_oe_n = vecs[i].oe_n; chip_we_n = vecs[i].we_n;
         chip_bhe_n = vecs[i].bhe_n; chip_ble_n = vecs[i].ble_n;
         chip_refresh = vecs[i].refresh; chip_addr = vecs[i].addr;
         chip_wdata = vecs[i].wdata;
         settle();
         chk($sformatf("vec%0d_ram", i),
             64'({ram_refresh, ram_bhe_n, ram_ble_n, ram_we_n, ram_oe_n, ram_addr, ram_data}),
             64'(vecs[i].exp_ram));
         tick(); settle();
         chk($sformatf("vec%0d_noack", i), 64'({cpu_ready, cpu_reject}), 64'd0);
      end
      cpu_sel = 0; chip_oe_n = 1; chip_we_n = 1; chip_bhe_n = 1; chip_ble_n = 1;
      chip_refresh = 0; chip_addr = 23'h000200; chip_wdata = 16'h0000;
      tick();

      // Chipset read in a slot wins over a pending CPU read.
      slots_on = 1;
      wait_slot();
      chip_oe_n = 0; chip_addr = 23'h000100;
      cpu_sel = 1; cpu_rnw = 1; cpu_addr = 23'h0A0000;
      settle();
      chk("chipslot_addr", 64'(ram_addr), 64'h000100);
      chk("chipslot_oe_n", 64'(ram_oe_n), 64'd0);
      tick();
      chip_oe_n = 1; cpu_sel = 0; chip_addr = 23'h000200;
      for (int i = 1; i <= 3; i++) begin
         settle();
         chk($sformatf("chipslot_t%0d", i), 64'({cpu_ready, ram_oe_n}), 64'b01);
         tick();
      end

      // Back-to-back CPU reads in consecutive slots.
      wait_slot();
      cpu_sel = 1; cpu_rnw = 1; cpu_addr = 23'h0A0000;
      exp_q.push_back(16'hBEEF);
      settle();
      chk("rd_t0_oe_n", 64'(ram_oe_n), 64'd1);
      tick(); settle();
      chk("rd_t1", 64'({ram_oe_n, ram_we_n, ram_addr}), {40'd0, 1'b0, 1'b1, 23'h0A0000});
      tick(); settle();
      chk("rd_t2", 64'({ram_oe_n, cpu_ready}), 64'b00);
      tick(); settle();
      chk("rd_t3_ready", 64'(cpu_ready), 64'd1);
      chk("rd_t3_rdata", 64'(cpu_rdata), 64'(exp_q.pop_front()));
      cpu_addr = 23'h0A0002;
      exp_q.push_back(16'h0F0F);
      tick(); settle();
      chk("rd2_slot", 64'({clk7_en, cpu_ready}), 64'b10);
      tick(); settle();
      chk("rd2_drive", 64'({ram_oe_n, ram_addr}), {40'd0, 1'b0, 23'h0A0002});
      wait_ready("rd2", 2);

      // Refresh pre-empts a granted CPU read; the read retries next slot.
      wait_slot();
      cpu_sel = 1; cpu_rnw = 1; cpu_addr = 23'h0A0001;
      exp_q.push_back(16'h1357);
      tick();
      chip_refresh = 1;
      settle();
      chk("pre_t1", 64'({ram_refresh, ram_oe_n, ram_addr}), {40'd0, 1'b1, 1'b1, 23'h000200});
      tick();
      chip_refresh = 0;
      settle();
      chk("pre_t2", 64'({conflict, cpu_ready, ram_oe_n}), 64'b101);
      wait_ready("pre_retry", 5);
      chk("pre_sticky", 64'(conflict), 64'd1);

`ifdef TURBO_WRITE_EN
      wait_slot();
      cpu_sel = 1; cpu_rnw = 0; cpu_addr = 23'h000010; cpu_wdata = 16'h1234;
      cpu_uds = 1; cpu_lds = 0;
      exp_q.push_back(16'h1357);
      for (int i = 1; i <= 2; i++) begin
         tick(); settle();
         chk($sformatf("wr_t%0d", i),
             64'({ram_we_n, ram_bhe_n, ram_ble_n, ram_oe_n, cpu_reject, ram_data}),
             {43'd0, 5'b00110, 16'h1234});
      end
      wait_ready("wr", 1);
      cpu_uds = 1; cpu_lds = 1;
      tick();
      chk("wr_mem", 64'(mem[midx(23'h000010)]), 64'h1200);

      wait_slot();
      cpu_sel = 1; cpu_rnw = 0; cpu_addr = 23'h7C0002; cpu_wdata = 16'hAAAA;
      exp_q.push_back(16'h1357);
      for (int i = 1; i <= 2; i++) begin
         tick(); settle();
         chk($sformatf("wp_t%0d", i), 64'({ram_we_n, ram_oe_n, ram_addr}),
             {40'd0, 1'b1, 1'b1, 23'h7C0002});
      end
      wait_ready("wp", 1);
      tick();
      chk("wp_mem", 64'(mem[midx(23'h7C0002)]), 64'h5555);
`else
      wait_slot();
      cpu_sel = 1; cpu_rnw = 0; cpu_addr = 23'h000010; cpu_wdata = 16'h1234;
      cpu_uds = 1; cpu_lds = 0;
      settle();
      chk("rej_t0", 64'({cpu_reject, ram_we_n}), 64'b01);
      tick(); settle();
      chk("rej_t1", 64'({cpu_reject, ram_we_n, cpu_ready}), 64'b110);
      cpu_sel = 0; cpu_uds = 1; cpu_lds = 1;
      tick(); settle();
      chk("rej_t2", 64'({cpu_reject, ram_we_n}), 64'b01);
      chk("rej_mem", 64'(mem[midx(23'h000010)]), 64'h0000);
`endif

      // Reset in the middle of a CPU read.
      wait_slot();
      cpu_sel = 1; cpu_rnw = 1; cpu_addr = 23'h0A0000;
      tick(); settle();
      chk("rstacc_t1", 64'(ram_oe_n), 64'd0);
      reset = 1;
      tick(); settle();
      chk("rstacc_t2", 64'({ram_oe_n, cpu_ready, conflict}), 64'b100);
      reset = 0; cpu_sel = 0;
      tick(); settle();
      chk("rstacc_t3", 64'({cpu_ready, cpu_rdata}), 64'd0);
      tick(); settle();
      chk("rstacc_t4", 64'(cpu_ready), 64'd0);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
